// File: rtl/mmmmmmmm_a_pkg.sv
// rtl/mmmmmmmm_a_pkg.sv - shared constants for the 8-input Batcher sorter
// Purpose: default data width and the compare-exchange wiring of the
//          19-element, 6-layer odd-even merge network.
// Lane i of the network carries operand i (A=0 .. H=7); after the last
// layer lane 0 holds the minimum and lane 7 the maximum.
package mmmmmmmm_a_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int N_IN      = 8;

  // Comparators of layer k occupy indices LAYER_BASE[k] .. LAYER_BASE[k+1]-1.
  localparam int LAYER_BASE [0:6] = '{0, 4, 8, 10, 14, 16, 19};

  // Lane feeding the low (min) and high (max) side of each comparator.
  localparam int CMP_LO [0:18] = '{0, 2, 4, 6,  0, 1, 4, 5,  1, 5,
                                   0, 1, 2, 3,  2, 3,  1, 3, 5};
  localparam int CMP_HI [0:18] = '{1, 3, 5, 7,  2, 3, 6, 7,  2, 6,
                                   4, 5, 6, 7,  4, 5,  2, 4, 6};

  // Bit i set: lane i is untouched by that layer and passes straight through.
  localparam logic [7:0] LAYER_PASS [0:5] = '{8'h00, 8'h00, 8'h99,
                                              8'h00, 8'hC3, 8'h81};

endpackage

// File: rtl/mmmmmmmm_a_cmp_swap.sv
// rtl/mmmmmmmm_a_cmp_swap.sv - combinational unsigned compare-exchange
// Purpose: lo = min(x,y), hi = max(x,y); equal operands pass unchanged.
// Ports:   x, y  (in,  WIDTH) operands
//          lo    (out, WIDTH) smaller value
//          hi    (out, WIDTH) larger value
module cmp_swap #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic w_swap;

  // Swap only on strict less-than so ties keep their original sides.
  assign w_swap = (y < x);
  assign lo     = w_swap ? y : x;
  assign hi     = w_swap ? x : y;

endmodule

// File: rtl/mmmmmmmm_a.sv
// rtl/mmmmmmmm_a.sv - pipelined 8-input Batcher odd-even merge sorter
// Purpose: sorts A..H ascending onto Y7 (min) .. Y0 (max), 3-cycle latency,
//          one set accepted per clock, no backpressure.
// Ports:   clk        clock, rising edge
//          rst_n      asynchronous active-low reset
//          in_valid   A..H carry a set this cycle
//          out_valid  Y7..Y0 carry a sorted set this cycle
//          Y7..Y0     sorted outputs (WIDTH each)
//          A..H       unsigned operands (WIDTH each)
module mmmmmmmm_a
  import mmmmmmmm_a_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             out_valid,
  output logic [WIDTH-1:0] Y7,
  output logic [WIDTH-1:0] Y6,
  output logic [WIDTH-1:0] Y5,
  output logic [WIDTH-1:0] Y4,
  output logic [WIDTH-1:0] Y3,
  output logic [WIDTH-1:0] Y2,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y0,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] E,
  input  logic [WIDTH-1:0] F,
  input  logic [WIDTH-1:0] G,
  input  logic [WIDTH-1:0] H
);

  // One array per layer boundary keeps every net acyclic.
  logic [WIDTH-1:0] w_in0 [N_IN];
  logic [WIDTH-1:0] w_l1  [N_IN];
  logic [WIDTH-1:0] w_l2  [N_IN];
  logic [WIDTH-1:0] r_p1  [N_IN];
  logic [WIDTH-1:0] w_l3  [N_IN];
  logic [WIDTH-1:0] w_l4  [N_IN];
  logic [WIDTH-1:0] r_p2  [N_IN];
  logic [WIDTH-1:0] w_l5  [N_IN];
  logic [WIDTH-1:0] w_l6  [N_IN];
  logic [WIDTH-1:0] r_p3  [N_IN];
  logic [2:0]       r_vld;

  assign w_in0[0] = A;
  assign w_in0[1] = B;
  assign w_in0[2] = C;
  assign w_in0[3] = D;
  assign w_in0[4] = E;
  assign w_in0[5] = F;
  assign w_in0[6] = G;
  assign w_in0[7] = H;

  // Layer 1: sort adjacent pairs
  for (genvar c = LAYER_BASE[0]; c < LAYER_BASE[1]; c++) begin : g_l1
    cmp_swap #(.WIDTH(WIDTH)) u_cs (
      .x (w_in0[CMP_LO[c]]), .y (w_in0[CMP_HI[c]]),
      .lo(w_l1[CMP_LO[c]]),  .hi(w_l1[CMP_HI[c]])
    );
  end

  // Layer 2: first step of merging pairs into sorted quads
  for (genvar c = LAYER_BASE[1]; c < LAYER_BASE[2]; c++) begin : g_l2
    cmp_swap #(.WIDTH(WIDTH)) u_cs (
      .x (w_l1[CMP_LO[c]]), .y (w_l1[CMP_HI[c]]),
      .lo(w_l2[CMP_LO[c]]), .hi(w_l2[CMP_HI[c]])
    );
  end

  // Layer 3: finish quad merge (middle lanes only)
  for (genvar c = LAYER_BASE[2]; c < LAYER_BASE[3]; c++) begin : g_l3
    cmp_swap #(.WIDTH(WIDTH)) u_cs (
      .x (r_p1[CMP_LO[c]]), .y (r_p1[CMP_HI[c]]),
      .lo(w_l3[CMP_LO[c]]), .hi(w_l3[CMP_HI[c]])
    );
  end
  for (genvar i = 0; i < N_IN; i++) begin : g_p3
    if (LAYER_PASS[2][i]) begin : g_t
      assign w_l3[i] = r_p1[i];
    end
  end

  // Layer 4: start merging the two quads
  for (genvar c = LAYER_BASE[3]; c < LAYER_BASE[4]; c++) begin : g_l4
    cmp_swap #(.WIDTH(WIDTH)) u_cs (
      .x (w_l3[CMP_LO[c]]), .y (w_l3[CMP_HI[c]]),
      .lo(w_l4[CMP_LO[c]]), .hi(w_l4[CMP_HI[c]])
    );
  end

  // Layer 5
  for (genvar c = LAYER_BASE[4]; c < LAYER_BASE[5]; c++) begin : g_l5
    cmp_swap #(.WIDTH(WIDTH)) u_cs (
      .x (r_p2[CMP_LO[c]]), .y (r_p2[CMP_HI[c]]),
      .lo(w_l5[CMP_LO[c]]), .hi(w_l5[CMP_HI[c]])
    );
  end
  for (genvar i = 0; i < N_IN; i++) begin : g_p5
    if (LAYER_PASS[4][i]) begin : g_t
      assign w_l5[i] = r_p2[i];
    end
  end

  // Layer 6: final clean-up of neighbouring inner lanes
  for (genvar c = LAYER_BASE[5]; c < LAYER_BASE[6]; c++) begin : g_l6
    cmp_swap #(.WIDTH(WIDTH)) u_cs (
      .x (w_l5[CMP_LO[c]]), .y (w_l5[CMP_HI[c]]),
      .lo(w_l6[CMP_LO[c]]), .hi(w_l6[CMP_HI[c]])
    );
  end
  for (genvar i = 0; i < N_IN; i++) begin : g_p6
    if (LAYER_PASS[5][i]) begin : g_t
      assign w_l6[i] = w_l5[i];
    end
  end

  // Data banks load every edge; only the valid bit qualifies them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) begin
        r_p1[i] <= '0;
        r_p2[i] <= '0;
        r_p3[i] <= '0;
      end
      r_vld <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        r_p1[i] <= w_l2[i];
        r_p2[i] <= w_l4[i];
        r_p3[i] <= w_l6[i];
      end
      r_vld <= {r_vld[1:0], in_valid};
    end
  end

  assign out_valid = r_vld[2];
  assign Y7 = r_p3[0];
  assign Y6 = r_p3[1];
  assign Y5 = r_p3[2];
  assign Y4 = r_p3[3];
  assign Y3 = r_p3[4];
  assign Y2 = r_p3[5];
  assign Y1 = r_p3[6];
  assign Y0 = r_p3[7];

endmodule

// File: tb/tb_mmmmmmmm_a.sv
// tb/tb_mmmmmmmm_a.sv - self-checking bench for the 8-input sorter
module tb_mmmmmmmm_a;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_valid;
  logic [7:0] A = '0, B = '0, C = '0, D = '0, E = '0, F = '0, G = '0, H = '0;
  logic [7:0] Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [63:0] ins;   // {A,B,C,D,E,F,G,H}
    logic [63:0] exp;   // {Y7,Y6,...,Y0}
  } vec_t;

  vec_t        tbl [5];
  logic [63:0] st  [31];

  always #5 clk = ~clk;

  mmmmmmmm_a #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .out_valid(out_valid),
    .Y7(Y7), .Y6(Y6), .Y5(Y5), .Y4(Y4), .Y3(Y3), .Y2(Y2), .Y1(Y1), .Y0(Y0),
    .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .H(H)
  );

  task automatic drive(input logic v, input logic [63:0] s);
    in_valid = v;
    {A, B, C, D, E, F, G, H} = s;
  endtask

  function automatic logic [63:0] y_all();
    return {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_sort(input logic [63:0] v);
    logic [7:0]  a [8];
    logic [7:0]  t;
    logic [63:0] r;
    for (int i = 0; i < 8; i++) a[i] = v[63-8*i -: 8];
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    for (int i = 0; i < 8; i++) r[63-8*i -: 8] = a[i];
    return r;
  endfunction

  function automatic int count_val(input logic [63:0] v, input logic [7:0] x);
    int n = 0;
    for (int i = 0; i < 8; i++) if (v[8*i +: 8] == x) n++;
    return n;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = {64'h0807060504030201, 64'h0102030405060708};
    tbl[1] = {64'hFF00C8C80011FF63, 64'h00001163C8C8FFFF};
    tbl[2] = {64'h0102030405060708, 64'h0102030405060708};
    tbl[3] = {64'h5A5A5A5A5A5A5A5A, 64'h5A5A5A5A5A5A5A5A};
    tbl[4] = {64'h0301040105090206, 64'h0101020304050609};

    // Asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("reset_y", y_all(), 64'h0);
    chk("reset_vld", {63'h0, out_valid}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_vld", {63'h0, out_valid}, 64'h0);

    // Table vectors, one at a time, latency checked on both sides
    foreach (tbl[i]) begin
      @(negedge clk); drive(1'b1, tbl[i].ins);
      @(negedge clk); drive(1'b0, 64'h0);
      @(negedge clk);
      chk($sformatf("vec%0d_early_vld", i), {63'h0, out_valid}, 64'h0);
      @(negedge clk);
      chk($sformatf("vec%0d_y", i), y_all(), tbl[i].exp);
      chk($sformatf("vec%0d_vld", i), {63'h0, out_valid}, 64'h1);
    end

    // Back-to-back streaming, set 15 carries H == F
    foreach (st[k]) st[k] = {$urandom(), $urandom()};
    st[15][7:0] = st[15][23:16];
    for (int k = 0; k <= 34; k++) begin
      @(negedge clk);
      if (k >= 3 && k <= 33) begin
        chk($sformatf("stream%0d_y", k - 3), y_all(), ref_sort(st[k-3]));
        chk($sformatf("stream%0d_vld", k - 3), {63'h0, out_valid}, 64'h1);
        if (k - 3 == 15)
          chk("stream_h_eq_f_dup", {63'h0, count_val(y_all(), st[15][23:16]) >= 2}, 64'h1);
      end
      if (k == 34) chk("stream_end_vld", {63'h0, out_valid}, 64'h0);
      if (k < 31) drive(1'b1, st[k]);
      else        drive(1'b0, 64'h0);
    end

    // in_valid gap pattern 1,0,1
    repeat (3) @(negedge clk);
    drive(1'b1, tbl[0].ins);
    @(negedge clk); drive(1'b0, 64'h0);
    @(negedge clk); drive(1'b1, tbl[1].ins);
    @(negedge clk); drive(1'b0, 64'h0);
    chk("gap_vld0", {63'h0, out_valid}, 64'h1);
    chk("gap_y0", y_all(), tbl[0].exp);
    @(negedge clk);
    chk("gap_vld1", {63'h0, out_valid}, 64'h0);
    @(negedge clk);
    chk("gap_vld2", {63'h0, out_valid}, 64'h1);
    chk("gap_y2", y_all(), tbl[1].exp);
    @(negedge clk);
    chk("gap_vld3", {63'h0, out_valid}, 64'h0);

    // Reset mid-stream with two sets still in flight
    repeat (2) @(negedge clk);
    drive(1'b1, tbl[2].ins);
    @(negedge clk); drive(1'b1, tbl[3].ins);
    @(negedge clk); drive(1'b1, tbl[4].ins);
    @(negedge clk); drive(1'b0, 64'h0);
    chk("pre_rst_vld", {63'h0, out_valid}, 64'h1);
    chk("pre_rst_y", y_all(), tbl[2].exp);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_y", y_all(), 64'h0);
    chk("mid_rst_vld", {63'h0, out_valid}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_vld%0d", k), {63'h0, out_valid}, 64'h0);
    end

    // First set after release keeps the 3-cycle latency
    drive(1'b1, tbl[1].ins);
    @(negedge clk); drive(1'b0, 64'h0);
    @(negedge clk);
    chk("rel_early_vld", {63'h0, out_valid}, 64'h0);
    @(negedge clk);
    chk("rel_vld", {63'h0, out_valid}, 64'h1);
    chk("rel_y", y_all(), tbl[1].exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mmmmmmmm_a.md
MMMMMMMM_A -- requirements
Module: mmmmmmmm_a

Interface
REQ-001 Parameter WIDTH, default 8: bit width of every data input and output.
REQ-002 Port list order SHALL be clk, rst_n, in_valid, out_valid, Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0, A, B, C, D, E, F, G, H.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  A..H carry a set to be sorted this cycle.
REQ-006 out_valid  output  1  Y7..Y0 hold a sorted result this cycle.
REQ-007 Y7..Y0  output  WIDTH each  sorted result; Y7 = minimum, Y0 = maximum.
REQ-008 A..H  input  WIDTH each  unsigned operands to be sorted.

Function
REQ-009 The block SHALL output the eight inputs as a permutation in ascending order from Y7 to Y0: Y7 <= Y6 <= ... <= Y0.
REQ-010 Comparison SHALL be unsigned and WIDTH bits wide, with no sign extension.
REQ-011 Equal inputs SHALL be duplicated, never dropped: the output multiset equals the input multiset.
REQ-012 Sorting SHALL use a Batcher odd-even merge network: 19 compare-exchange elements in 6 layers.
REQ-013 Pipeline registers SHALL sit after layers 2, 4 and 6, giving a latency of exactly 3 clk cycles from the sampling edge to the output.
REQ-014 A..H and in_valid SHALL be sampled on every rising clk edge, giving a throughput of one set per cycle with no stalls.
REQ-015 out_valid SHALL equal in_valid delayed by 3 cycles, aligned with its data.
REQ-016 Data registers SHALL load on every edge regardless of in_valid; Y values are don't-care while out_valid = 0.
REQ-017 Each compare-exchange element SHALL place min(x,y) on its low output and max(x,y) on its high output.
REQ-018 When x == y, the element SHALL pass both values unchanged.
REQ-019 No handshake backpressure SHALL exist; the consumer must accept each result in its out_valid cycle.

Reset
REQ-020 While rst_n = 0, all pipeline registers, Y7..Y0 and out_valid SHALL be 0, asynchronously and without waiting for a clk edge.
REQ-021 Reset asserted mid-operation SHALL discard all in-flight sets; no out_valid pulse for them SHALL appear after release.
REQ-022 After rst_n deasserts, the first out_valid SHALL occur 3 cycles after the first edge that samples in_valid = 1.

Structure
REQ-023 A shared package SHALL hold the WIDTH default and the comparator index pairs per layer as constants.
REQ-024 One sub-module, cmp_swap, SHALL be instantiated 19 times.
  - purely combinational
  - inputs x, y; outputs lo, hi; parameter WIDTH
REQ-025 The top module SHALL contain only cmp_swap instances, the three pipeline register banks and the valid shift register.

Verification
REQ-026 Distinct values: A..H = 8,7,6,5,4,3,2,1 with in_valid = 1 -> 3 cycles later Y7..Y0 = 1,2,3,4,5,6,7,8 and out_valid = 1.
REQ-027 Duplicates and extremes: A..H = 255,0,200,200,0,17,255,99 -> Y7..Y0 = 0,0,17,99,200,200,255,255.
REQ-028 Already sorted and all-equal inputs:
  - A..H = 1..8 -> Y7..Y0 = 1..8
  - all inputs = 0x5A -> every output = 0x5A
REQ-029 Back-to-back streaming: 30 random sets on consecutive cycles, plus one set with H = F.
  - each result appears exactly 3 cycles after its input, in order
  - each result matches a reference sort
  - the H = F set shows the value twice
REQ-030 Reset mid-stream: assert rst_n = 0 asynchronously between edges with 2 sets in flight.
  - outputs and out_valid go to 0 at once
  - after release, no stale out_valid appears
REQ-031 in_valid gaps: pattern 1,0,1 -> out_valid pattern 1,0,1 starting at cycle 3.
